// File: rtl/frame_buf_pkg.sv
// Shared encodings and defaults for the ping-pong frame buffer writer.
// Select encodings are one-hot in the order {buf1, blank, buf0}.
package frame_buf_pkg;

  localparam int DEF_PIX_W     = 8;
  localparam int DEF_FRAME_PIX = 64;
  localparam int DEF_ADDR_W    = 6;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_WAIT = 2'd2
  } wstate_t;

  typedef enum logic [2:0] {
    SEL_BUF0  = 3'b001,
    SEL_BLANK = 3'b010,
    SEL_BUF1  = 3'b100
  } sel_t;

  // Front buffer after a swap: the previous back buffer (buffer 0 while blank).
  function automatic sel_t next_front(input sel_t cur);
    case (cur)
      SEL_BLANK: next_front = SEL_BUF0;
      SEL_BUF0:  next_front = SEL_BUF1;
      SEL_BUF1:  next_front = SEL_BUF0;
      default:   next_front = SEL_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// Frame address counter: counts 0..FRAME_PIX-1 and wraps back to 0.
// Clear together with enable means the current item takes address 0, so the count becomes 1.
module frame_addr_counter #(
  parameter int FRAME_PIX = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_en ? ONE : '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST_ADDR) ? '0 : r_cnt + ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/frame_buf_writer.sv
// Ping-pong frame buffer write/swap controller: fills the back buffer from the pixel
// stream, swaps front/back at display vsync and drives the display read address.
module frame_buf_writer
  import frame_buf_pkg::*;
#(
  parameter int PIX_W     = DEF_PIX_W,
  parameter int FRAME_PIX = DEF_FRAME_PIX,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              buf0_we,
  output logic              buf1_we,
  input  logic              disp_vsync,
  input  logic              disp_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              sel_buf0,
  output logic              sel_blank,
  output logic              sel_buf1,
  output logic              frame_drop
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  wstate_t           r_state;
  wstate_t           w_state_nxt;
  sel_t              r_sel;
  sel_t              w_sel_nxt;

  logic              w_xfer;
  logic              w_wr;
  logic              w_drop;
  logic              w_cnt_clr;
  logic              w_back_is_buf1;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_wr_cnt;
  logic [ADDR_W-1:0] w_wr_addr_nxt;

  logic [ADDR_W-1:0] r_wr_addr;
  logic [PIX_W-1:0]  r_wr_data;
  logic              r_buf0_we;
  logic              r_buf1_we;
  logic              r_frame_drop;

  // Ready is held low while reset is asserted even though the state is already W_IDLE.
  assign pix_ready      = rst_n & (r_state != W_WAIT);
  assign w_xfer         = pix_valid & pix_ready;
  assign w_back_is_buf1 = (r_sel == SEL_BUF0);
  assign w_wr_addr_nxt  = pix_sof ? '0 : w_wr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= W_IDLE;
      r_sel   <= SEL_BLANK;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // frame_rdy is exactly the W_WAIT state; a swap is only taken from there, so a vsync
  // coinciding with the last-pixel transfer is deferred to the following vsync.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_wr        = 1'b0;
    w_drop      = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      W_IDLE: begin
        if (w_xfer && pix_sof) begin
          w_wr        = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = W_FILL;
        end
      end
      W_FILL: begin
        if (w_xfer) begin
          w_wr = 1'b1;
          if (pix_sof) begin
            w_cnt_clr = 1'b1;
            w_drop    = 1'b1;
          end else if (w_wr_cnt == LAST_ADDR) begin
            w_state_nxt = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (disp_vsync) begin
          w_sel_nxt   = next_front(r_sel);
          w_state_nxt = W_IDLE;
        end
      end
      default: begin
        w_state_nxt = W_IDLE;
      end
    endcase
  end

  frame_addr_counter #(
    .FRAME_PIX (FRAME_PIX),
    .ADDR_W    (ADDR_W)
  ) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cnt_clr),
    .i_en  (w_wr),
    .o_cnt (w_wr_cnt)
  );

  // vsync has priority over disp_en on the read side.
  assign w_rd_en = disp_en & ~disp_vsync;

  frame_addr_counter #(
    .FRAME_PIX (FRAME_PIX),
    .ADDR_W    (ADDR_W)
  ) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (disp_vsync),
    .i_en  (w_rd_en),
    .o_cnt (rd_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_buf0_we    <= 1'b0;
      r_buf1_we    <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_buf0_we    <= w_wr & ~w_back_is_buf1;
      r_buf1_we    <= w_wr & w_back_is_buf1;
      r_frame_drop <= w_drop;
      if (w_wr) begin
        r_wr_addr <= w_wr_addr_nxt;
        r_wr_data <= pix_data;
      end
    end
  end

  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign buf0_we    = r_buf0_we;
  assign buf1_we    = r_buf1_we;
  assign frame_drop = r_frame_drop;

  assign {sel_buf1, sel_blank, sel_buf0} = r_sel;

endmodule

// File: tb/tb_frame_buf_writer.sv
// Directed testbench for frame_buf_writer: fill, swap, restart, reset and read-address cases.
module tb_frame_buf_writer;

  localparam int PIX_W     = 8;
  localparam int FRAME_PIX = 64;
  localparam int ADDR_W    = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [PIX_W-1:0]  pix_data = '0;
  logic              pix_valid = 1'b0;
  logic              pix_sof = 1'b0;
  logic              pix_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              buf0_we;
  logic              buf1_we;
  logic              disp_vsync = 1'b0;
  logic              disp_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic              sel_buf0;
  logic              sel_blank;
  logic              sel_buf1;
  logic              frame_drop;

  int n_checks = 0;
  int n_errors = 0;
  int n_b0 = 0;
  int n_b1 = 0;
  int n_both = 0;
  int n_selbad = 0;
  int n_drop = 0;

  always #5 clk = ~clk;

  frame_buf_writer #(
    .PIX_W     (PIX_W),
    .FRAME_PIX (FRAME_PIX),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .buf0_we    (buf0_we),
    .buf1_we    (buf1_we),
    .disp_vsync (disp_vsync),
    .disp_en    (disp_en),
    .rd_addr    (rd_addr),
    .sel_buf0   (sel_buf0),
    .sel_blank  (sel_blank),
    .sel_buf1   (sel_buf1),
    .frame_drop (frame_drop)
  );

  // Strobe / select tallies sampled mid-cycle.
  always @(negedge clk) begin
    if (buf0_we === 1'b1) n_b0 <= n_b0 + 1;
    if (buf1_we === 1'b1) n_b1 <= n_b1 + 1;
    if (buf0_we === 1'b1 && buf1_we === 1'b1) n_both <= n_both + 1;
    if (frame_drop === 1'b1) n_drop <= n_drop + 1;
    if ({sel_buf1, sel_blank, sel_buf0} !== 3'b001 &&
        {sel_buf1, sel_blank, sel_buf0} !== 3'b010 &&
        {sel_buf1, sel_blank, sel_buf0} !== 3'b100) n_selbad <= n_selbad + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input logic [PIX_W-1:0] d, input logic sof, input logic vs);
    pix_data   = d;
    pix_sof    = sof;
    pix_valid  = 1'b1;
    disp_vsync = vs;
    step();
    pix_valid  = 1'b0;
    pix_sof    = 1'b0;
    disp_vsync = 1'b0;
  endtask

  task automatic pulse_vsync();
    disp_vsync = 1'b1;
    step();
    disp_vsync = 1'b0;
  endtask

  task automatic test_reset();
    int b0, b1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({sel_buf1, sel_blank, sel_buf0} !== 3'b010 || rd_addr !== 6'd0 || pix_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_sel: got sel=%b rd=%0d rdy=%b expected sel=010 rd=0 rdy=0",
               {sel_buf1, sel_blank, sel_buf0}, rd_addr, pix_ready);
    end
    n_checks++;
    if (wr_addr !== 6'd0 || wr_data !== 8'h00 || buf0_we !== 1'b0 || buf1_we !== 1'b0 || frame_drop !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_wr: got addr=%0d data=%h we0=%b we1=%b drop=%b expected all 0",
               wr_addr, wr_data, buf0_we, buf1_we, frame_drop);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (pix_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: got %b expected 1", pix_ready);
    end
    b0 = n_b0; b1 = n_b1;
    repeat (4) step();
    n_checks++;
    if (n_b0 != b0 || n_b1 != b1 || sel_blank !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_idle: got strobes0=%0d strobes1=%0d blank=%b expected 0 0 1",
               n_b0 - b0, n_b1 - b1, sel_blank);
    end
  endtask

  task automatic test_first_frame();
    for (int i = 0; i < FRAME_PIX; i++) begin
      n_checks++;
      if (pix_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL f1_ready[%0d]: got %b expected 1", i, pix_ready);
      end
      drive_pix(8'(i), i == 0, 1'b0);
      n_checks++;
      if (buf0_we !== 1'b1 || buf1_we !== 1'b0 || wr_addr !== 6'(i) || wr_data !== 8'(i)) begin
        n_errors++;
        $display("FAIL f1_write[%0d]: got we0=%b we1=%b addr=%0d data=%h expected 1 0 %0d %h",
                 i, buf0_we, buf1_we, wr_addr, wr_data, i, 8'(i));
      end
    end
    n_checks++;
    if (pix_ready !== 1'b0 || sel_blank !== 1'b1) begin
      n_errors++;
      $display("FAIL f1_wait: got rdy=%b blank=%b expected 0 1", pix_ready, sel_blank);
    end
    step();
    n_checks++;
    if (buf0_we !== 1'b0) begin
      n_errors++;
      $display("FAIL f1_strobe_end: got we0=%b expected 0", buf0_we);
    end
    pulse_vsync();
    n_checks++;
    if ({sel_buf1, sel_blank, sel_buf0} !== 3'b001 || pix_ready !== 1'b1 || rd_addr !== 6'd0) begin
      n_errors++;
      $display("FAIL f1_swap: got sel=%b rdy=%b rd=%0d expected sel=001 rdy=1 rd=0",
               {sel_buf1, sel_blank, sel_buf0}, pix_ready, rd_addr);
    end
  endtask

  task automatic test_rd_addr();
    disp_en = 1'b1;
    repeat (FRAME_PIX - 1) step();
    n_checks++;
    if (rd_addr !== 6'd63) begin
      n_errors++;
      $display("FAIL rd_count: got %0d expected 63", rd_addr);
    end
    step();
    n_checks++;
    if (rd_addr !== 6'd0) begin
      n_errors++;
      $display("FAIL rd_wrap: got %0d expected 0", rd_addr);
    end
    step();
    disp_vsync = 1'b1;
    step();
    disp_vsync = 1'b0;
    disp_en = 1'b0;
    n_checks++;
    if (rd_addr !== 6'd0 || sel_buf0 !== 1'b1) begin
      n_errors++;
      $display("FAIL rd_vsync_prio: got rd=%0d buf0=%b expected 0 1", rd_addr, sel_buf0);
    end
  endtask

  task automatic test_back_to_back();
    int b0, b1;
    b0 = n_b0; b1 = n_b1;
    for (int i = 0; i < FRAME_PIX; i++) begin
      drive_pix(8'(128 + i), i == 0, 1'b0);
      n_checks++;
      if (buf1_we !== 1'b1 || buf0_we !== 1'b0 || wr_addr !== 6'(i) || wr_data !== 8'(128 + i)) begin
        n_errors++;
        $display("FAIL f2_write[%0d]: got we0=%b we1=%b addr=%0d data=%h expected 0 1 %0d %h",
                 i, buf0_we, buf1_we, wr_addr, wr_data, i, 8'(128 + i));
      end
    end
    step();
    n_checks++;
    if (n_b1 - b1 != 64 || n_b0 != b0) begin
      n_errors++;
      $display("FAIL f2_strobes: got buf0=%0d buf1=%0d expected 0 64", n_b0 - b0, n_b1 - b1);
    end
    pulse_vsync();
    n_checks++;
    if ({sel_buf1, sel_blank, sel_buf0} !== 3'b100) begin
      n_errors++;
      $display("FAIL f2_swap: got sel=%b expected 100", {sel_buf1, sel_blank, sel_buf0});
    end
    b0 = n_b0; b1 = n_b1;
    for (int i = 0; i < FRAME_PIX; i++) drive_pix(8'(64 + i), i == 0, 1'b0);
    n_checks++;
    if (buf0_we !== 1'b1 || wr_addr !== 6'd63 || wr_data !== 8'h7F) begin
      n_errors++;
      $display("FAIL f3_last: got we0=%b addr=%0d data=%h expected 1 63 7f", buf0_we, wr_addr, wr_data);
    end
    step();
    pulse_vsync();
    n_checks++;
    if (n_b0 - b0 != 64 || n_b1 != b1 || {sel_buf1, sel_blank, sel_buf0} !== 3'b001) begin
      n_errors++;
      $display("FAIL f3_swap: got buf0=%0d buf1=%0d sel=%b expected 64 0 001",
               n_b0 - b0, n_b1 - b1, {sel_buf1, sel_blank, sel_buf0});
    end
  endtask

  task automatic test_vsync_no_frame();
    pulse_vsync();
    n_checks++;
    if ({sel_buf1, sel_blank, sel_buf0} !== 3'b001) begin
      n_errors++;
      $display("FAIL idle_vsync: got sel=%b expected 001", {sel_buf1, sel_blank, sel_buf0});
    end
    disp_en = 1'b1;
    for (int i = 0; i < 10; i++) drive_pix(8'(i + 16), i == 0, 1'b0);
    n_checks++;
    if (rd_addr !== 6'd10) begin
      n_errors++;
      $display("FAIL fill_rd: got %0d expected 10", rd_addr);
    end
    drive_pix(8'h55, 1'b0, 1'b1);
    n_checks++;
    if (rd_addr !== 6'd0 || sel_buf0 !== 1'b1 || buf1_we !== 1'b1 || wr_addr !== 6'd10 || wr_data !== 8'h55) begin
      n_errors++;
      $display("FAIL fill_vsync: got rd=%0d buf0=%b we1=%b addr=%0d data=%h expected 0 1 1 10 55",
               rd_addr, sel_buf0, buf1_we, wr_addr, wr_data);
    end
    disp_en = 1'b0;
    for (int i = 11; i < FRAME_PIX - 1; i++) drive_pix(8'(i), 1'b0, 1'b0);
    drive_pix(8'hEE, 1'b0, 1'b1);
    n_checks++;
    if (sel_buf0 !== 1'b1 || pix_ready !== 1'b0 || wr_addr !== 6'd63) begin
      n_errors++;
      $display("FAIL last_pix_vsync: got buf0=%b rdy=%b addr=%0d expected 1 0 63", sel_buf0, pix_ready, wr_addr);
    end
    step();
    pulse_vsync();
    n_checks++;
    if ({sel_buf1, sel_blank, sel_buf0} !== 3'b100) begin
      n_errors++;
      $display("FAIL deferred_swap: got sel=%b expected 100", {sel_buf1, sel_blank, sel_buf0});
    end
  endtask

  task automatic test_sof_restart();
    int d0;
    d0 = n_drop;
    for (int i = 0; i < 20; i++) drive_pix(8'(i), i == 0, 1'b0);
    drive_pix(8'hA0, 1'b1, 1'b0);
    n_checks++;
    if (frame_drop !== 1'b1 || wr_addr !== 6'd0 || buf0_we !== 1'b1 || wr_data !== 8'hA0) begin
      n_errors++;
      $display("FAIL restart: got drop=%b addr=%0d we0=%b data=%h expected 1 0 1 a0",
               frame_drop, wr_addr, buf0_we, wr_data);
    end
    drive_pix(8'hA1, 1'b0, 1'b0);
    n_checks++;
    if (frame_drop !== 1'b0 || wr_addr !== 6'd1) begin
      n_errors++;
      $display("FAIL restart_next: got drop=%b addr=%0d expected 0 1", frame_drop, wr_addr);
    end
    for (int i = 2; i < FRAME_PIX; i++) drive_pix(8'(160 + i), 1'b0, 1'b0);
    n_checks++;
    if (pix_ready !== 1'b0 || wr_addr !== 6'd63) begin
      n_errors++;
      $display("FAIL restart_done: got rdy=%b addr=%0d expected 0 63", pix_ready, wr_addr);
    end
    step();
    pulse_vsync();
    n_checks++;
    if (n_drop - d0 != 1 || {sel_buf1, sel_blank, sel_buf0} !== 3'b001) begin
      n_errors++;
      $display("FAIL restart_swap: got drops=%0d sel=%b expected 1 001",
               n_drop - d0, {sel_buf1, sel_blank, sel_buf0});
    end
  endtask

  task automatic test_reset_midframe();
    disp_en = 1'b1;
    for (int i = 0; i < 30; i++) drive_pix(8'(i), i == 0, 1'b0);
    pix_data  = 8'd30;
    pix_valid = 1'b1;
    rst_n     = 1'b0;
    #2;
    n_checks++;
    if ({sel_buf1, sel_blank, sel_buf0} !== 3'b010 || rd_addr !== 6'd0 || wr_addr !== 6'd0 ||
        wr_data !== 8'h00 || buf0_we !== 1'b0 || buf1_we !== 1'b0 || frame_drop !== 1'b0 || pix_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset: got sel=%b rd=%0d addr=%0d data=%h we0=%b we1=%b drop=%b rdy=%b expected 010 0 0 00 0 0 0 0",
               {sel_buf1, sel_blank, sel_buf0}, rd_addr, wr_addr, wr_data, buf0_we, buf1_we, frame_drop, pix_ready);
    end
    pix_valid = 1'b0;
    disp_en   = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    pulse_vsync();
    n_checks++;
    if ({sel_buf1, sel_blank, sel_buf0} !== 3'b010 || pix_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_vsync: got sel=%b rdy=%b expected 010 1", {sel_buf1, sel_blank, sel_buf0}, pix_ready);
    end
    drive_pix(8'h33, 1'b0, 1'b0);
    n_checks++;
    if (buf0_we !== 1'b0 || buf1_we !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_discard: got we0=%b we1=%b expected 0 0", buf0_we, buf1_we);
    end
    drive_pix(8'h44, 1'b1, 1'b0);
    n_checks++;
    if (buf0_we !== 1'b1 || buf1_we !== 1'b0 || wr_addr !== 6'd0 || wr_data !== 8'h44) begin
      n_errors++;
      $display("FAIL midreset_refill: got we0=%b we1=%b addr=%0d data=%h expected 1 0 0 44",
               buf0_we, buf1_we, wr_addr, wr_data);
    end
    step();
  endtask

  task automatic test_integrity();
    n_checks++;
    if (n_both != 0 || n_selbad != 0) begin
      n_errors++;
      $display("FAIL integrity: got both_we=%0d bad_sel=%0d expected 0 0", n_both, n_selbad);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_rd_addr();
    test_back_to_back();
    test_vsync_no_frame();
    test_sof_restart();
    test_reset_midframe();
    test_integrity();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
